loopback_arbiter: RTL
=====================

Name: loopback_arbiter

Overview:
- Shares a single loopback HLS component instance among NUM_REQ requesters over its call/return streaming interface.
- Round-robin arbitration on the call side; registered call slot drives start/idx.
- Tracks in-flight requester IDs in an in-order tag FIFO; the component returns results in call order.
- Routes each done/returndata back to the owning requester, propagating that requester's backpressure into the component's return stall.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
IDX_W, 32, width of idx argument
DATA_W, 32, width of returndata
MAX_OUTSTANDING, 8, max calls issued but not yet returned; power of 2, 2..64
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clock  in  1  single clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester call request
req_idx  in  NUM_REQ*IDX_W  per-requester idx, requester i at bits [i*IDX_W +: IDX_W]
req_ready  out  NUM_REQ  one-hot accept; a request is taken when req_valid[i] && req_ready[i]
rsp_valid  out  NUM_REQ  one-hot result valid
rsp_data  out  DATA_W  result data, shared by all requesters
rsp_ready  in  NUM_REQ  per-requester result accept
lb_start  out  1  component call.valid
lb_idx  out  IDX_W  component idx.data
lb_busy  in  1  component call.stall
lb_done  in  1  component return.valid
lb_stall  out  1  component return.stall
lb_returndata  in  DATA_W  component returndata.data
outstanding  out  clog2(MAX_OUTSTANDING)+1  calls in call slot plus tag FIFO
proto_err  out  1  sticky: lb_done seen with no call outstanding

Behaviour:
- Reset values: call slot empty, so lb_start=0 and lb_idx=0. Tag FIFO empty, RR pointer=0, outstanding=0, proto_err=0.
- Asynchronous reset mid-operation discards all in-flight state. The component must be reset in the same window.
- Call slot:
  - Holds {valid, idx, tag}. lb_start = slot valid; lb_idx = slot idx.
  - Accepted by the component when lb_start && !lb_busy. The tag is pushed to the FIFO that same cycle.
  - Slot contents stay stable while lb_busy=1.
- Arbitration:
  - Arbitration is enabled when the slot is empty or being accepted this cycle, and outstanding < MAX_OUTSTANDING after counting any pop this cycle.
  - Grant goes to the first i with req_valid[i], scanning from the RR pointer upward with wrap.
  - req_ready is combinational and one-hot: set only for the granted i, and all zero when arbitration is disabled.
  - On grant: the slot loads {1, req_idx[i], i}; the RR pointer becomes (i+1) mod NUM_REQ.
  - With no grant, the slot clears when accepted.
  - A newly granted request reaches lb_start the next cycle, so call latency is 1 cycle minimum.
- Return path (combinational):
  - h = FIFO head tag.
  - rsp_valid[h] = lb_done && FIFO non-empty; rsp_data = lb_returndata.
  - lb_stall = lb_done && non-empty && !rsp_ready[h].
  - FIFO pops on lb_done && non-empty && rsp_ready[h].
- Simultaneous push and pop in one cycle is legal; the FIFO count is unchanged.
- outstanding = slot valid + FIFO count. It never exceeds MAX_OUTSTANDING.
- Full FIFO: no new grants are made; a pop in the same cycle re-enables a grant.
- lb_done while the FIFO is empty:
  - rsp_valid stays 0 and lb_stall stays 0, so the data is dropped.
  - proto_err sets and holds until reset.
- Requesters not at the FIFO head never see rsp_valid. Results are strictly in call order.

Optional Feature:
- Macro LOOPBACK_ARBITER_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_err (1 bit, sticky, reset 0) and an internal counter.
  - The counter clears on any pop or when the FIFO is empty, and increments while the FIFO is non-empty.
  - timeout_err sets when the counter reaches TIMEOUT_CYCLES and holds until reset.
  - Arbitration is unaffected.
- Not defined: no port, no counter, TIMEOUT_CYCLES unused.

Test Plan:
- Single call: reset, then req_valid[2]=1 with idx=0x10. Expect req_ready[2] in cycle 0 and lb_start with lb_idx=0x10 in cycle 1. The component returns 0x10 → rsp_valid=4'b0100, rsp_data=0x10, outstanding back to 0.
- Round-robin: all four req_valid held high, lb_busy=0, no returns. Expect grants in order 0,1,2,3,0,… until outstanding=8, then req_ready=0.
- Backpressure: lb_busy=1 for 5 cycles with the slot loaded. Expect lb_idx stable, req_ready=0, and acceptance on the first cycle lb_busy=0.
- Return stall: head tag=1 and rsp_ready[1]=0 for 3 cycles while lb_done=1. Expect lb_stall=1 for 3 cycles, no pop, then a pop when rsp_ready[1]=1.
- Full plus simultaneous: outstanding=8 with a pop and a pending request in the same cycle. Expect a grant that cycle and outstanding to stay at 8.
- Errors: lb_done with an empty FIFO → proto_err=1, rsp_valid=0. With LOOPBACK_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, one call and no done → timeout_err=1 after 16 cycles. Assert reset mid-traffic → all outputs return to reset values.

Source files
------------

// File: rtl/loopback_arbiter.sv
// Round-robin sharing of one loopback HLS call/return interface among NUM_REQ requesters; optional watchdog via LOOPBACK_ARBITER_TIMEOUT_EN.
// Latency: grant to lb_start 1 cycle; return path is combinational.
// Backpressure: lb_busy holds the call slot; the head requester's rsp_ready drives lb_stall.

module loopback_arbiter_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

module loopback_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int IDX_W           = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]           req_idx,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_W-1:0]                  rsp_data,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic                               lb_start,
    output logic [IDX_W-1:0]                   lb_idx,
    input  logic                               lb_busy,
    input  logic                               lb_done,
    output logic                               lb_stall,
    input  logic [DATA_W-1:0]                  lb_returndata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
`ifdef LOOPBACK_ARBITER_TIMEOUT_EN
    output logic                               timeout_err,
`endif
    output logic                               proto_err
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int TW1   = TAG_W + 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 64 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("loopback_arbiter: parameter out of range");
    end

    logic [IDX_W-1:0] idx_arr [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_idx
        assign idx_arr[g] = req_idx[g*IDX_W +: IDX_W];
    end

    logic             slot_vld;
    logic [IDX_W-1:0] slot_idx;
    logic [TAG_W-1:0] slot_tag;
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_ne;
    logic             accept;
    logic             pop;
    logic             arb_en;
    logic             grant_vld;
    logic [TAG_W-1:0] grant_id;
    logic [TW1-1:0]   cand;

    assign fifo_ne     = (fifo_cnt != '0);
    assign accept      = slot_vld && !lb_busy;
    assign pop         = lb_done && fifo_ne && rsp_ready[head_tag];
    assign outstanding = fifo_cnt + {{(CNT_W-1){1'b0}}, slot_vld};
    // A pop this cycle frees a place, so a full tracker can still grant.
    assign arb_en      = (!slot_vld || accept) &&
                         ((outstanding - {{(CNT_W-1){1'b0}}, pop}) < MAX_CNT);

    assign lb_start = slot_vld;
    assign lb_idx   = slot_idx;
    assign rsp_data = lb_returndata;
    assign lb_stall = lb_done && fifo_ne && !rsp_ready[head_tag];

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + TW1'(k);
            if (cand >= TW1'(NUM_REQ)) cand = cand - TW1'(NUM_REQ);
            if (arb_en && !grant_vld && req_valid[cand[TAG_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[TAG_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (grant_vld)          req_ready[grant_id] = 1'b1;
        if (lb_done && fifo_ne) rsp_valid[head_tag] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_vld  <= 1'b0;
            slot_idx  <= '0;
            slot_tag  <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (grant_vld) begin
                slot_vld <= 1'b1;
                slot_idx <= idx_arr[grant_id];
                slot_tag <= grant_id;
                rr_ptr   <= (grant_id == LAST_TAG) ? '0 : grant_id + 1'b1;
            end else if (accept) begin
                slot_vld <= 1'b0;
            end
            if (lb_done && !fifo_ne) proto_err <= 1'b1;
        end
    end

    loopback_arbiter_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (slot_tag),
        .pop       (pop),
        .head      (head_tag),
        .count     (fifo_cnt)
    );

`ifdef LOOPBACK_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop || !fifo_ne)    to_cnt <= '0;
            else if (to_cnt != TO_LIM) to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LIM) timeout_err <= 1'b1;
        end
    end
`endif
endmodule
